// File: rtl/muldiv_unit_pkg.sv
// Shared types for the execute-stage multiply/divide unit.
//   muldiv_op_t    : funct3 encoding of the M-extension operations
//   muldiv_state_t : sequencing states of muldiv_unit
//   control_t      : decode fields that steer an instruction into the unit
package muldiv_unit_pkg;

    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } muldiv_op_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } muldiv_state_t;

    typedef struct packed {
        logic       is_muldiv;
        muldiv_op_t mdop;
        logic       mdword;
    } control_t;

    // Wide enough for 63 divide iterations and up to 8 multiply cycles.
    localparam int MD_CNT_W = 7;

endpackage

// File: rtl/muldiv_divider.sv
// Iterative radix-2 restoring divider on unsigned magnitudes.
// One quotient bit per cycle; 32 iterations when word=1, WIDTH otherwise.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   abort             drop the division in progress
//   start             load dividend/divisor and begin
//   word              select a 32-bit iteration count
//   dividend, divisor unsigned magnitudes (upper half zero in word mode)
//   quotient, remainder  value after the step taken this cycle
//   valid             high in the cycle whose step is the last one
module muldiv_divider
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             abort,
    input  logic             start,
    input  logic             word,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             valid
);

    logic                run_r;
    logic [MD_CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0]    rem_r;
    logic [WIDTH-1:0]    quo_r;
    logic [WIDTH-1:0]    dvs_r;

    logic [WIDTH:0]      shift_s;
    logic                ge_s;
    logic [WIDTH-1:0]    diff_s;
    logic [WIDTH-1:0]    rem_next_s;
    logic [WIDTH-1:0]    quo_next_s;

    // One restoring step: shift the next dividend bit in, subtract if it fits.
    always_comb begin
        shift_s = {rem_r, quo_r[WIDTH-1]};
        ge_s    = (shift_s >= {1'b0, dvs_r});
        // The difference is below the divisor whenever it is kept, so WIDTH bits suffice.
        diff_s  = shift_s[WIDTH-1:0] - dvs_r;
        if (ge_s) begin
            rem_next_s = diff_s;
        end else begin
            rem_next_s = shift_s[WIDTH-1:0];
        end
        quo_next_s = {quo_r[WIDTH-2:0], ge_s};
    end

    assign quotient  = quo_next_s;
    assign remainder = rem_next_s;
    assign valid     = run_r && (cnt_r == {MD_CNT_W{1'b0}});

    // Iteration state: load on start, step while running.
    always_ff @(posedge clk) begin
        if (reset) begin
            run_r <= 1'b0;
            cnt_r <= {MD_CNT_W{1'b0}};
            rem_r <= {WIDTH{1'b0}};
            quo_r <= {WIDTH{1'b0}};
            dvs_r <= {WIDTH{1'b0}};
        end else if (start) begin
            run_r <= 1'b1;
            cnt_r <= word ? MD_CNT_W'(31) : MD_CNT_W'(WIDTH - 1);
            rem_r <= {WIDTH{1'b0}};
            // Left-align a word dividend so its MSB is shifted out first.
            quo_r <= word ? (dividend << 32) : dividend;
            dvs_r <= divisor;
        end else if (abort) begin
            run_r <= 1'b0;
        end else if (run_r) begin
            rem_r <= rem_next_s;
            quo_r <= quo_next_s;
            cnt_r <= cnt_r - MD_CNT_W'(1);
            if (valid) begin
                run_r <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RV64M multiply/divide unit beside the execute-stage ALU.
// Ports:
//   clk, reset  clock, synchronous active-high reset
//   start       request valid; op/word/a/b captured when accepted
//   op          funct3 (MUL..REMU), word selects the *W forms
//   a, b        rs1 / rs2 operands
//   flush       abort the operation in flight, result discarded
//   ready       a start can be accepted this cycle
//   busy        operation in flight (stall request)
//   done        one-cycle result-valid pulse
//   result      last completed result, stable until the next one registers
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH      = 64,
    parameter int MUL_CYCLES = 2,
    parameter int HAS_WORD   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic             word,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int                  XW       = WIDTH + 1;
    localparam int                  PW       = 2 * WIDTH;
    localparam logic                WORD_EN  = (HAS_WORD != 0);
    localparam logic [MD_CNT_W-1:0] MUL_LOAD = MD_CNT_W'(MUL_CYCLES - 1);

    // Extend an operand to XW bits; word mode uses only the low 32 bits.
    function automatic logic [XW-1:0] ext_op(input logic [WIDTH-1:0] x, input logic sgn,
                                             input logic wd);
        logic [XW-1:0] r;
        if (wd && sgn) begin
            r = XW'($signed(x[31:0]));
        end else if (wd) begin
            r = XW'(x[31:0]);
        end else begin
            r = {sgn & x[WIDTH-1], x};
        end
        return r;
    endfunction

    // Word results are always sign-extended from bit 31, unsigned forms included.
    function automatic logic [WIDTH-1:0] sext_word(input logic [WIDTH-1:0] x, input logic wd);
        logic [WIDTH-1:0] r;
        if (wd) begin
            r = WIDTH'($signed(x[31:0]));
        end else begin
            r = x;
        end
        return r;
    endfunction

    // Magnitude of an extended operand; the most-negative value still fits WIDTH bits.
    function automatic logic [WIDTH-1:0] mag(input logic [XW-1:0] x);
        return WIDTH'(x[XW-1] ? -x : x);
    endfunction

    muldiv_state_t       state_r, state_next_s;
    logic [MD_CNT_W-1:0] counter_r, counter_next_s;
    muldiv_op_t          op_r;
    logic                word_r;
    logic [XW-1:0]       opa_r, opb_r;
    logic                qneg_r, rneg_r;
    logic [WIDTH-1:0]    result_r;
    logic                ready_r, busy_r, done_r;

    muldiv_op_t          op_in_s;
    logic                word_in_s, sa_in_s, sb_in_s;
    logic [XW-1:0]       ea_in_s, eb_in_s, mn_s;
    logic                accept_s, is_div_in_s, bz_in_s, ovf_in_s;

    logic                mul_lat_s, mword_s;
    muldiv_op_t          mop_s;
    logic [XW-1:0]       ma_s, mb_s;
    logic [PW-1:0]       prod_s;
    logic [WIDTH-1:0]    mul_res_s;

    logic                div_start_s, div_valid_s, is_rem_s;
    logic [WIDTH-1:0]    div_q_s, div_r_s, div_res_s, fix_res_s;

    logic                res_load_s;
    logic [WIDTH-1:0]    res_next_s;

    assign op_in_s     = muldiv_op_t'(op);
    assign word_in_s   = WORD_EN & word;
    assign is_div_in_s = op[2];
    assign accept_s    = start & ready_r & ~flush;

    // Operand signedness from funct3.
    always_comb begin
        sa_in_s = 1'b0;
        sb_in_s = 1'b0;
        case (op_in_s)
            MD_MULH:        begin sa_in_s = 1'b1; sb_in_s = 1'b1; end
            MD_MULHSU:      begin sa_in_s = 1'b1; sb_in_s = 1'b0; end
            MD_DIV, MD_REM: begin sa_in_s = 1'b1; sb_in_s = 1'b1; end
            default:        begin sa_in_s = 1'b0; sb_in_s = 1'b0; end
        endcase
    end

    assign ea_in_s  = ext_op(a, sa_in_s, word_in_s);
    assign eb_in_s  = ext_op(b, sb_in_s, word_in_s);
    // Most-negative N-bit value, sign-extended to XW bits.
    assign mn_s     = word_in_s ? {{(XW-31){1'b1}}, 31'h0} : {2'b11, {(WIDTH-1){1'b0}}};
    assign bz_in_s  = (eb_in_s == {XW{1'b0}});
    assign ovf_in_s = sa_in_s & is_div_in_s & (ea_in_s == mn_s) & (eb_in_s == {XW{1'b1}});

    // The multiplier sees the incoming operands only when MUL_CYCLES=1 finishes at accept.
    assign mul_lat_s = (state_r == ST_MUL);
    assign ma_s      = mul_lat_s ? opa_r  : ea_in_s;
    assign mb_s      = mul_lat_s ? opb_r  : eb_in_s;
    assign mop_s     = mul_lat_s ? op_r   : op_in_s;
    assign mword_s   = mul_lat_s ? word_r : word_in_s;
    assign prod_s    = PW'($signed(ma_s) * $signed(mb_s));
    assign mul_res_s = (mop_s == MD_MUL) ? sext_word(prod_s[WIDTH-1:0], mword_s)
                     : sext_word(mword_s ? WIDTH'(prod_s[63:32]) : prod_s[PW-1:WIDTH], mword_s);

    assign div_start_s = accept_s & is_div_in_s & ~bz_in_s & ~ovf_in_s;

    muldiv_divider #(.WIDTH(WIDTH)) u_divider (
        .clk       (clk),
        .reset     (reset),
        .abort     (flush),
        .start     (div_start_s),
        .word      (word_in_s),
        .dividend  (mag(ea_in_s)),
        .divisor   (mag(eb_in_s)),
        .quotient  (div_q_s),
        .remainder (div_r_s),
        .valid     (div_valid_s)
    );

    assign is_rem_s  = (op_r == MD_REM) || (op_r == MD_REMU);
    assign div_res_s = sext_word(is_rem_s ? (rneg_r ? -div_r_s : div_r_s)
                                          : (qneg_r ? -div_q_s : div_q_s), word_r);

    // Special cases: divide by zero (q=-1, r=a) or signed overflow (q=a, r=0).
    always_comb begin
        fix_res_s = {WIDTH{1'b0}};
        if (opb_r == {XW{1'b0}}) begin
            fix_res_s = is_rem_s ? opa_r[WIDTH-1:0] : {WIDTH{1'b1}};
        end else begin
            fix_res_s = is_rem_s ? {WIDTH{1'b0}} : opa_r[WIDTH-1:0];
        end
        fix_res_s = sext_word(fix_res_s, word_r);
    end

    // Next state, counter and result load.
    always_comb begin
        state_next_s   = state_r;
        counter_next_s = counter_r;
        res_load_s     = 1'b0;
        res_next_s     = result_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (accept_s) begin
                    if (!is_div_in_s) begin
                        if (MUL_CYCLES <= 1) begin
                            state_next_s   = ST_DONE;
                            counter_next_s = {MD_CNT_W{1'b0}};
                            res_load_s     = 1'b1;
                            res_next_s     = mul_res_s;
                        end else begin
                            state_next_s   = ST_MUL;
                            counter_next_s = MUL_LOAD;
                        end
                    end else if (bz_in_s || ovf_in_s) begin
                        state_next_s   = ST_FIX;
                        counter_next_s = {MD_CNT_W{1'b0}};
                    end else begin
                        state_next_s   = ST_DIV;
                        counter_next_s = word_in_s ? MD_CNT_W'(31) : MD_CNT_W'(WIDTH - 1);
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (flush) begin
                    state_next_s   = ST_IDLE;
                    counter_next_s = {MD_CNT_W{1'b0}};
                end else if (counter_r <= MD_CNT_W'(1)) begin
                    state_next_s   = ST_DONE;
                    counter_next_s = {MD_CNT_W{1'b0}};
                    res_load_s     = 1'b1;
                    res_next_s     = mul_res_s;
                end else begin
                    counter_next_s = counter_r - MD_CNT_W'(1);
                end
            end
            ST_DIV: begin
                if (flush) begin
                    state_next_s   = ST_IDLE;
                    counter_next_s = {MD_CNT_W{1'b0}};
                end else if (div_valid_s) begin
                    state_next_s   = ST_DONE;
                    counter_next_s = {MD_CNT_W{1'b0}};
                    res_load_s     = 1'b1;
                    res_next_s     = div_res_s;
                end else begin
                    counter_next_s = counter_r - MD_CNT_W'(1);
                end
            end
            ST_FIX: begin
                if (flush) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                    res_load_s   = 1'b1;
                    res_next_s   = fix_res_s;
                end
            end
            default: begin
                state_next_s   = ST_IDLE;
                counter_next_s = {MD_CNT_W{1'b0}};
            end
        endcase
    end

    // State, captured operands, registered status flags and result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            counter_r <= {MD_CNT_W{1'b0}};
            op_r      <= MD_MUL;
            word_r    <= 1'b0;
            opa_r     <= {XW{1'b0}};
            opb_r     <= {XW{1'b0}};
            qneg_r    <= 1'b0;
            rneg_r    <= 1'b0;
            result_r  <= {WIDTH{1'b0}};
            ready_r   <= 1'b1;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            counter_r <= counter_next_s;
            ready_r   <= (state_next_s == ST_IDLE) || (state_next_s == ST_DONE);
            busy_r    <= (state_next_s == ST_MUL) || (state_next_s == ST_DIV) ||
                         (state_next_s == ST_FIX);
            done_r    <= (state_next_s == ST_DONE);
            if (res_load_s) begin
                result_r <= res_next_s;
            end
            if (accept_s) begin
                op_r   <= op_in_s;
                word_r <= word_in_s;
                opa_r  <= ea_in_s;
                opb_r  <= eb_in_s;
                // Extended sign bits are zero for unsigned ops, so no extra gating.
                qneg_r <= ea_in_s[XW-1] ^ eb_in_s[XW-1];
                rneg_r <= ea_in_s[XW-1];
            end
        end
    end

    assign ready  = ready_r;
    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (WIDTH=64, MUL_CYCLES=2, HAS_WORD=1).
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset, start, word, flush;
    logic [2:0]  op;
    logic [63:0] a, b;
    logic        ready, busy, done;
    logic [63:0] result;
    int          checks = 0;
    int          errors = 0;
    logic        seen;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(64), .MUL_CYCLES(2), .HAS_WORD(1)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .word(word),
        .a(a), .b(b), .flush(flush), .ready(ready), .busy(busy),
        .done(done), .result(result)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one op, wait (bounded) for done, check latency from accept and result.
    task automatic run_op(input string tag, input logic [2:0] o, input logic w,
                          input logic [63:0] x, input logic [63:0] y,
                          input logic [63:0] exp_res, input int exp_lat);
        int lat;
        @(negedge clk);
        op = o; word = w; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " result"}, result, exp_res);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; word = 1'b0; flush = 1'b0;
        op = 3'b000; a = 64'd0; b = 64'd0;
        repeat (3) @(negedge clk);
        check("rst ready", 64'(ready), 64'd1);
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst result", result, 64'd0);
        reset = 1'b0;

        // MUL 7 * -3 with cycle-by-cycle status
        @(negedge clk);
        op = MD_MUL; word = 1'b0; a = 64'd7; b = 64'hFFFF_FFFF_FFFF_FFFD; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("mul T+1 busy", 64'(busy), 64'd1);
        check("mul T+1 ready", 64'(ready), 64'd0);
        check("mul T+1 done", 64'(done), 64'd0);
        @(negedge clk);
        check("mul T+2 done", 64'(done), 64'd1);
        check("mul T+2 busy", 64'(busy), 64'd0);
        check("mul T+2 result", result, 64'hFFFF_FFFF_FFFF_FFEB);

        run_op("mulhu", MD_MULHU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
               64'hFFFF_FFFF_FFFF_FFFE, 2);
        run_op("mulhsu", MD_MULHSU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,
               64'hFFFF_FFFF_FFFF_FFFF, 2);
        run_op("mulh", MD_MULH, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
               64'd0, 2);
        run_op("mulw", MD_MUL, 1'b1, 64'h1234_5678_7FFF_FFFF, 64'd2,
               64'hFFFF_FFFF_FFFF_FFFE, 2);
        run_op("div", MD_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3,
               64'hFFFF_FFFF_FFFF_FFFA, 65);
        run_op("rem", MD_REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3,
               64'hFFFF_FFFF_FFFF_FFFE, 65);
        run_op("divu", MD_DIVU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10,
               64'h0FFF_FFFF_FFFF_FFFF, 65);
        run_op("remu", MD_REMU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'hF, 65);
        run_op("divuw", MD_DIVU, 1'b1, 64'h0000_0000_FFFF_FFFE, 64'd1,
               64'hFFFF_FFFF_FFFF_FFFE, 33);
        run_op("divw", MD_DIV, 1'b1, 64'hAAAA_AAAA_FFFF_FFF9, 64'd2,
               64'hFFFF_FFFF_FFFF_FFFD, 33);
        run_op("remw", MD_REM, 1'b1, 64'hAAAA_AAAA_FFFF_FFF9, 64'd2,
               64'hFFFF_FFFF_FFFF_FFFF, 33);
        run_op("divu by0", MD_DIVU, 1'b0, 64'd123, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2);
        run_op("rem by0", MD_REM, 1'b0, 64'd5, 64'd0, 64'd5, 2);
        run_op("div ovf", MD_DIV, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
               64'h8000_0000_0000_0000, 2);
        run_op("remw ovf", MD_REM, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
               64'd0, 2);
        run_op("mul pre", MD_MUL, 1'b0, 64'd6, 64'd7, 64'd42, 2);

        // Flush a DIV in cycle T+10 while start is also asserted
        @(negedge clk);
        op = MD_DIV; word = 1'b0; a = 64'd1000; b = 64'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = done;
        for (int i = 2; i <= 10; i++) begin
            @(negedge clk);
            seen = seen | done;
        end
        flush = 1'b1; start = 1'b1; op = MD_MUL; a = 64'd5; b = 64'd9;
        @(negedge clk);
        flush = 1'b0;
        check("flush no done", 64'(seen | done), 64'd0);
        check("flush busy", 64'(busy), 64'd0);
        check("flush ready", 64'(ready), 64'd1);
        check("flush result kept", result, 64'd42);
        @(negedge clk);
        start = 1'b0;
        check("post-flush mul busy", 64'(busy), 64'd1);
        @(negedge clk);
        check("post-flush mul done", 64'(done), 64'd1);
        check("post-flush mul result", result, 64'd45);

        // Flush together with start during DONE: pulse already seen, nothing accepted
        flush = 1'b1; start = 1'b1; op = MD_MUL; a = 64'd2; b = 64'd2;
        @(negedge clk);
        flush = 1'b0; start = 1'b0;
        check("done flush busy", 64'(busy), 64'd0);
        check("done flush done", 64'(done), 64'd0);
        check("done flush result", result, 64'd45);

        // start held across two MULs; operands changed while busy are ignored
        @(negedge clk);
        op = MD_MUL; word = 1'b0; a = 64'd3; b = 64'd5; start = 1'b1;
        @(negedge clk);
        a = 64'd6; b = 64'd7;
        check("b2b T+1 done", 64'(done), 64'd0);
        @(negedge clk);
        check("b2b T+2 done", 64'(done), 64'd1);
        check("b2b T+2 result", result, 64'd15);
        @(negedge clk);
        check("b2b T+3 done", 64'(done), 64'd0);
        check("b2b T+3 busy", 64'(busy), 64'd1);
        @(negedge clk);
        start = 1'b0;
        check("b2b T+4 done", 64'(done), 64'd1);
        check("b2b T+4 result", result, 64'd42);
        @(negedge clk);
        check("b2b T+5 done", 64'(done), 64'd0);

        // Reset in the middle of a DIV
        @(negedge clk);
        op = MD_DIV; a = 64'd100; b = 64'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst ready", 64'(ready), 64'd1);
        check("midrst busy", 64'(busy), 64'd0);
        check("midrst done", 64'(done), 64'd0);
        check("midrst result", result, 64'd0);

        run_op("divu after rst", MD_DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 65);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
